// File: rtl/seq_chk_pkg.sv
// Shared types for the sequence checker: per-thread state record and saturating add.
package seq_chk_pkg;

  typedef enum logic {THR_IDLE, THR_WAIT} thr_state_e;

  // Step and counter fields are sized for NSTEP <= 256 and DLY_W <= 8.
  localparam int THR_FIELD_W = 8;

  typedef struct packed {
    thr_state_e             state;
    logic [THR_FIELD_W-1:0] step;
    logic [THR_FIELD_W-1:0] cnt;
  } thr_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] cur,
                                          input logic [31:0] inc,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

endpackage

// File: rtl/seq_chk_thread.sv
// One sequence attempt: waits on step k, counting cycles since the previous step matched.
// SEQ_CHK_SVA_EN adds a step-range assertion.
module seq_chk_thread
  import seq_chk_pkg::*;
#(
  parameter int NSTEP = 4,
  parameter int DLY_W = 4,
  parameter int LEN_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   kill,
  input  logic                   alloc,
  input  logic [LEN_W-1:0]       len,
  input  logic [NSTEP-1:0]       step_sig,
  input  logic [NSTEP*DLY_W-1:0] min_flat,
  input  logic [NSTEP*DLY_W-1:0] max_flat,
  output logic                   active,
  output logic                   pass,
  output logic                   fail
);

  localparam int STEP_W = $clog2(NSTEP);

  thr_t                   thr_q, thr_d;
  logic [STEP_W-1:0]      step_idx;
  logic [THR_FIELD_W-1:0] cnt_n, min_k, max_k;
  logic                   hit, last;

  assign step_idx = thr_q.step[STEP_W-1:0];
  assign cnt_n    = thr_q.cnt + THR_FIELD_W'(1);
  assign min_k    = THR_FIELD_W'(min_flat[step_idx*DLY_W +: DLY_W]);
  assign max_k    = THR_FIELD_W'(max_flat[step_idx*DLY_W +: DLY_W]);
  assign hit      = (thr_q.state == THR_WAIT) && (cnt_n >= min_k) && (cnt_n <= max_k)
                    && step_sig[step_idx];
  assign last     = thr_q.step == (THR_FIELD_W'(len) - THR_FIELD_W'(1));
  assign active   = thr_q.state == THR_WAIT;

  // NOTE: every output of this block gets a default before any branch, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    thr_d = thr_q;
    pass  = 1'b0;
    fail  = 1'b0;
    if (kill) begin
      thr_d = '{state: THR_IDLE, step: '0, cnt: '0};
    end else if (thr_q.state == THR_WAIT) begin
      if (hit) begin
        if (last) begin
          pass        = 1'b1;
          thr_d.state = THR_IDLE;
        end else begin
          thr_d.step = thr_q.step + THR_FIELD_W'(1);
          thr_d.cnt  = '0;
        end
      end else if (cnt_n >= max_k) begin
        fail        = 1'b1;
        thr_d.state = THR_IDLE;
      end else begin
        thr_d.cnt = cnt_n;
      end
    end else if (alloc) begin
      thr_d = '{state: THR_WAIT, step: THR_FIELD_W'(1), cnt: '0};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) thr_q <= '{state: THR_IDLE, step: '0, cnt: '0};
    else        thr_q <= thr_d;
  end

`ifdef SEQ_CHK_SVA_EN
  a_step_range: assert property (@(posedge clk) disable iff (!rst_n)
    (thr_q.state == THR_WAIT) |-> (thr_q.step < THR_FIELD_W'(len)))
    else $error("seq_chk_thread: waiting on step beyond cfg_len");
`endif

endmodule

// File: rtl/seq_chk_engine.sv
// Synthesizable checker for "s0 ##[min1:max1] s1 ... sN" with NTHR overlapping attempts.
// SEQ_CHK_SVA_EN adds embedded concurrent assertions; behaviour is otherwise identical.
module seq_chk_engine
  import seq_chk_pkg::*;
#(
  parameter  int NSIG  = 3,
  parameter  int NSTEP = 4,
  parameter  int NTHR  = 4,
  parameter  int DLY_W = 4,
  parameter  int CNT_W = 16,
  localparam int SEL_W = $clog2(NSIG),
  localparam int LEN_W = $clog2(NSTEP) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [NSIG-1:0]        sig,
  input  logic [LEN_W-1:0]       cfg_len,
  input  logic [NSTEP*SEL_W-1:0] cfg_sel,
  input  logic [NSTEP*DLY_W-1:0] cfg_min,
  input  logic [NSTEP*DLY_W-1:0] cfg_max,
  output logic                   pass,
  output logic                   fail,
  output logic                   drop,
  output logic                   busy,
  output logic [CNT_W-1:0]       pass_cnt,
  output logic [CNT_W-1:0]       fail_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LEN_W-1:0]       len_q, len_d, len_s;
  logic [NSTEP*SEL_W-1:0] sel_q, sel_d;
  logic [NSTEP*DLY_W-1:0] min_q, min_d, max_q, max_d, min_s, max_s;
  logic [(1<<SEL_W)-1:0]  sig_ext;
  logic [NSTEP-1:0]       step_sig;
  logic [NTHR-1:0]        thr_active, thr_pass, thr_fail, thr_alloc;
  logic                   start, start_pass, need, found;
  logic [31:0]            n_pass, n_fail;
  logic                   pass_q, pass_d, fail_q, fail_d, drop_q, drop_d, busy_q, busy_d;
  logic [CNT_W-1:0]       pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;

  // Out-of-range selects read as a signal that is never high.
  assign sig_ext = (1<<SEL_W)'(sig);

  always_comb begin
    len_d = en ? len_q : cfg_len;
    sel_d = en ? sel_q : cfg_sel;
    min_d = en ? min_q : cfg_min;
    max_d = en ? max_q : cfg_max;
  end

  always_comb begin
    len_s = len_q;
    if (len_q == '0)                  len_s = LEN_W'(1);
    else if (len_q > LEN_W'(NSTEP))   len_s = LEN_W'(NSTEP);
    min_s    = min_q;
    max_s    = max_q;
    step_sig = '0;
    for (int k = 0; k < NSTEP; k++) begin
      if (min_q[k*DLY_W +: DLY_W] == '0) min_s[k*DLY_W +: DLY_W] = DLY_W'(1);
      if (max_q[k*DLY_W +: DLY_W] < min_s[k*DLY_W +: DLY_W])
        max_s[k*DLY_W +: DLY_W] = min_s[k*DLY_W +: DLY_W];
      step_sig[k] = sig_ext[sel_q[k*SEL_W +: SEL_W]];
    end
  end

  for (genvar i = 0; i < NTHR; i++) begin : g_thr
    seq_chk_thread #(.NSTEP(NSTEP), .DLY_W(DLY_W), .LEN_W(LEN_W)) u_thr (
      .clk      (clk),
      .rst_n    (rst_n),
      .kill     (~en),
      .alloc    (thr_alloc[i]),
      .len      (len_s),
      .step_sig (step_sig),
      .min_flat (min_s),
      .max_flat (max_s),
      .active   (thr_active[i]),
      .pass     (thr_pass[i]),
      .fail     (thr_fail[i])
    );
  end

  always_comb begin
    start      = en & step_sig[0];
    start_pass = start & (len_s == LEN_W'(1));
    need       = start & ~start_pass;
    thr_alloc  = '0;
    found      = 1'b0;
    // A thread freed this cycle still reads as active, so it is reusable only next cycle.
    for (int i = 0; i < NTHR; i++) begin
      if (!found && !thr_active[i]) begin
        thr_alloc[i] = need;
        found        = 1'b1;
      end
    end
    n_pass = 32'(start_pass);
    n_fail = '0;
    for (int i = 0; i < NTHR; i++) begin
      n_pass = n_pass + 32'(thr_pass[i]);
      n_fail = n_fail + 32'(thr_fail[i]);
    end
    pass_d     = n_pass != '0;
    fail_d     = n_fail != '0;
    drop_d     = need & ~found;
    busy_d     = en & (|thr_active);
    pass_cnt_d = CNT_W'(sat_inc(32'(pass_cnt_q), n_pass, 32'(CNT_MAX)));
    fail_cnt_d = CNT_W'(sat_inc(32'(fail_cnt_q), n_fail, 32'(CNT_MAX)));
  end

  // NOTE: the cfg shadow is reset along with everything else, so enabling straight
  // out of reset runs a defined one-step program instead of an unknown one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      sel_q      <= '0;
      min_q      <= '0;
      max_q      <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      drop_q     <= 1'b0;
      busy_q     <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      len_q      <= len_d;
      sel_q      <= sel_d;
      min_q      <= min_d;
      max_q      <= max_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      drop_q     <= drop_d;
      busy_q     <= busy_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign pass     = pass_q;
  assign fail     = fail_q;
  assign drop     = drop_q;
  assign busy     = busy_q;
  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;

`ifdef SEQ_CHK_SVA_EN
  a_cfg_hold: assert property (@(posedge clk) disable iff (!rst_n)
    $past(en) |-> $stable({len_q, sel_q, min_q, max_q}))
    else $error("seq_chk_engine: cfg shadow changed while enabled");
  a_quiet_off: assert property (@(posedge clk) disable iff (!rst_n)
    !$past(en) |-> !(pass_q | fail_q | drop_q))
    else $error("seq_chk_engine: pulse one cycle after disable");
  a_cnt_mono: assert property (@(posedge clk) disable iff (!rst_n)
    (pass_cnt_q >= $past(pass_cnt_q)) && (fail_cnt_q >= $past(fail_cnt_q)))
    else $error("seq_chk_engine: counter decreased");
`endif

endmodule

// File: tb/tb_seq_chk_engine.sv
// Randomised scoreboard bench for seq_chk_engine against a timestamp-based attempt model.
module tb_seq_chk_engine;

  localparam int NSIG    = 3;
  localparam int NSTEP   = 4;
  localparam int NTHR    = 2;
  localparam int DLY_W   = 4;
  localparam int CNT_W   = 6;
  localparam int SEL_W   = 2;
  localparam int LEN_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Step order a, b, c, a (step k at bits [2k+:2]).
  localparam logic [NSTEP*SEL_W-1:0] SEL_ABC = {2'd0, 2'd2, 2'd1, 2'd0};

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   en = 1'b0;
  logic [NSIG-1:0]        sig = '0;
  logic [LEN_W-1:0]       cfg_len = '0;
  logic [NSTEP*SEL_W-1:0] cfg_sel = '0;
  logic [NSTEP*DLY_W-1:0] cfg_min = '0;
  logic [NSTEP*DLY_W-1:0] cfg_max = '0;
  logic                   pass, fail, drop, busy;
  logic [CNT_W-1:0]       pass_cnt, fail_cnt;

  always #5 clk = ~clk;

  seq_chk_engine #(
    .NSIG(NSIG), .NSTEP(NSTEP), .NTHR(NTHR), .DLY_W(DLY_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig(sig),
    .cfg_len(cfg_len), .cfg_sel(cfg_sel), .cfg_min(cfg_min), .cfg_max(cfg_max),
    .pass(pass), .fail(fail), .drop(drop), .busy(busy),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  typedef struct {
    int pass, fail, drop, busy, pass_cnt, fail_cnt;
  } exp_t;

  typedef struct {
    int     step;
    longint last_t;
  } att_t;

  exp_t   exp_q[$];
  att_t   atts[$];
  int     sh_len;
  int     sh_sel[NSTEP];
  int     sh_min[NSTEP];
  int     sh_max[NSTEP];
  int     m_pass_cnt, m_fail_cnt;
  longint now;
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Each live attempt is the step it waits on plus the time of its last match.
  task automatic model_step();
    exp_t e;
    att_t keep[$];
    int   np, nf, n_before, len, k, d;
    int   mn[NSTEP];
    int   mx[NSTEP];
    e  = '{default: 0};
    np = 0;
    nf = 0;
    now++;
    if (!rst_n) begin
      atts.delete();
      sh_len = 0;
      for (int j = 0; j < NSTEP; j++) begin sh_sel[j] = 0; sh_min[j] = 0; sh_max[j] = 0; end
      m_pass_cnt = 0;
      m_fail_cnt = 0;
    end else if (!en) begin
      atts.delete();
      sh_len = int'(cfg_len);
      for (int j = 0; j < NSTEP; j++) begin
        sh_sel[j] = int'(cfg_sel[j*SEL_W +: SEL_W]);
        sh_min[j] = int'(cfg_min[j*DLY_W +: DLY_W]);
        sh_max[j] = int'(cfg_max[j*DLY_W +: DLY_W]);
      end
    end else begin
      len = (sh_len == 0) ? 1 : ((sh_len > NSTEP) ? NSTEP : sh_len);
      for (int j = 0; j < NSTEP; j++) begin
        mn[j] = (sh_min[j] == 0) ? 1 : sh_min[j];
        mx[j] = (sh_max[j] < mn[j]) ? mn[j] : sh_max[j];
      end
      n_before = atts.size();
      e.busy   = (n_before > 0) ? 1 : 0;
      foreach (atts[i]) begin
        k = atts[i].step;
        d = int'(now - atts[i].last_t);
        if (d >= mn[k] && d <= mx[k] && sig[sh_sel[k]]) begin
          if (k == len - 1) np++;
          else keep.push_back('{step: k + 1, last_t: now});
        end else if (d >= mx[k]) begin
          nf++;
        end else begin
          keep.push_back(atts[i]);
        end
      end
      atts = keep;
      if (sig[sh_sel[0]]) begin
        if (len == 1)            np++;
        else if (n_before < NTHR) atts.push_back('{step: 1, last_t: now});
        else                      e.drop = 1;
      end
      e.pass     = (np > 0) ? 1 : 0;
      e.fail     = (nf > 0) ? 1 : 0;
      m_pass_cnt = (m_pass_cnt + np > CNT_MAX) ? CNT_MAX : m_pass_cnt + np;
      m_fail_cnt = (m_fail_cnt + nf > CNT_MAX) ? CNT_MAX : m_fail_cnt + nf;
    end
    e.pass_cnt = m_pass_cnt;
    e.fail_cnt = m_fail_cnt;
    exp_q.push_back(e);
  endtask

  task automatic monitor_step();
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pass", 32'(pass), e.pass);
      check("fail", 32'(fail), e.fail);
      check("drop", 32'(drop), e.drop);
      check("busy", 32'(busy), e.busy);
      check("pass_cnt", 32'(pass_cnt), e.pass_cnt);
      check("fail_cnt", 32'(fail_cnt), e.fail_cnt);
    end
  endtask

  always @(posedge clk) model_step();
  always @(negedge clk) monitor_step();

  task automatic tick(input logic e, input logic [NSIG-1:0] s);
    @(negedge clk);
    #1;
    en  = e;
    sig = s;
  endtask

  task automatic program_cfg(input int len, input logic [NSTEP*SEL_W-1:0] sel,
                             input logic [NSTEP*DLY_W-1:0] mn, input logic [NSTEP*DLY_W-1:0] mx);
    tick(1'b0, '0);
    cfg_len = LEN_W'(len);
    cfg_sel = sel;
    cfg_min = mn;
    cfg_max = mx;
    tick(1'b0, '0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_pass", 32'(pass), 0);
    check("rst_fail", 32'(fail), 0);
    check("rst_drop", 32'(drop), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pass_cnt", 32'(pass_cnt), 0);
    check("rst_fail_cnt", 32'(fail_cnt), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // a, b, c in consecutive cycles passes; missing c, then missing b, fail.
    program_cfg(3, SEL_ABC, 16'h1111, 16'h1111);
    tick(1'b1, 3'b001); tick(1'b1, 3'b010); tick(1'b1, 3'b100);
    repeat (3) tick(1'b1, 3'b000);
    tick(1'b1, 3'b001); tick(1'b1, 3'b010); tick(1'b1, 3'b000);
    repeat (2) tick(1'b1, 3'b000);
    tick(1'b1, 3'b001); tick(1'b1, 3'b000);
    repeat (2) tick(1'b1, 3'b000);

    // Step 1 window [1:3]: b at +3 advances; b never fails at the window end.
    program_cfg(3, SEL_ABC, 16'h1111, 16'h1131);
    tick(1'b1, 3'b001); tick(1'b1, 3'b000); tick(1'b1, 3'b000);
    tick(1'b1, 3'b010); tick(1'b1, 3'b100);
    tick(1'b1, 3'b001);
    repeat (5) tick(1'b1, 3'b000);

    // Zero bounds sanitise to ##1.
    program_cfg(3, SEL_ABC, 16'h0000, 16'h0000);
    tick(1'b1, 3'b001); tick(1'b1, 3'b010); tick(1'b1, 3'b100);
    repeat (2) tick(1'b1, 3'b000);

    // Two threads, ##3: starts on the 3rd and 4th cycle drop, both threads pass.
    program_cfg(2, SEL_ABC, 16'h3333, 16'h3333);
    repeat (3) tick(1'b1, 3'b001);
    tick(1'b1, 3'b011); tick(1'b1, 3'b010);
    repeat (4) tick(1'b1, 3'b000);

    // Disable mid-attempt kills silently; cfg edits while enabled are ignored.
    program_cfg(3, SEL_ABC, 16'h1111, 16'h1111);
    tick(1'b1, 3'b001); tick(1'b0, 3'b010); tick(1'b1, 3'b100);
    cfg_len = LEN_W'(1);
    tick(1'b1, 3'b001); tick(1'b1, 3'b010); tick(1'b1, 3'b100);
    repeat (2) tick(1'b1, 3'b000);

    // Reset in the middle of an attempt.
    tick(1'b1, 3'b001); tick(1'b1, 3'b010);
    mid_reset();

    // Saturation of both counters.
    program_cfg(1, SEL_ABC, 16'h1111, 16'h1111);
    repeat (70) tick(1'b1, 3'b001);
    program_cfg(2, SEL_ABC, 16'h1111, 16'h1111);
    repeat (80) tick(1'b1, 3'b001);
    tick(1'b1, 3'b000);
    mid_reset();

    // Random traffic with random (often ignored) configuration.
    for (int c = 0; c < 3000; c++) begin
      if (c % 750 == 749) mid_reset();
      tick($urandom_range(0, 15) != 0, NSIG'($urandom_range(0, 7)));
      cfg_len = LEN_W'($urandom_range(0, 7));
      for (int k = 0; k < NSTEP; k++) begin
        cfg_sel[k*SEL_W +: SEL_W] = SEL_W'($urandom_range(0, 2));
        cfg_min[k*DLY_W +: DLY_W] = DLY_W'($urandom_range(0, 4));
        cfg_max[k*DLY_W +: DLY_W] = DLY_W'($urandom_range(0, 5));
      end
    end

    repeat (3) tick(1'b0, '0);
    @(negedge clk);
    #2;
    check("queue_drain", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
